// File: rtl/serial_bcd_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package serial_bcd_adder_pkg;

  localparam int unsigned DigitW = 4;
  localparam logic [4:0]  BcdTen = 5'd10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic digit_invalid(input logic [DigitW-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/serial_bcd_adder_if.sv
// Request/result bundle of the serial BCD adder.
interface serial_bcd_adder_if
  import serial_bcd_adder_pkg::*;
#(
  parameter int unsigned NDIG = 4
);
  logic                     start;
  logic [DigitW*NDIG-1:0]   a;
  logic [DigitW*NDIG-1:0]   b;
  logic                     cin;
  logic                     busy;
  logic                     done;
  logic [DigitW*NDIG-1:0]   sum;
  logic                     cout;
  logic                     err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/serial_bcd_adder_digit_add.sv
// One BCD digit add with decimal correction; non-BCD digits wrap, never saturate.
module bcd_digit_add
  import serial_bcd_adder_pkg::*;
(
  input  logic [DigitW-1:0] x,
  input  logic [DigitW-1:0] y,
  input  logic              ci,
  output logic [DigitW-1:0] s,
  output logic              co
);
  logic [4:0] f;
  logic [4:0] f_corr;

  always_comb begin
    f      = 5'(x) + 5'(y) + 5'(ci);
    f_corr = f - BcdTen;
    if (f >= BcdTen) begin
      s  = f_corr[DigitW-1:0];
      co = 1'b1;
    end else begin
      s  = f[DigitW-1:0];
      co = 1'b0;
    end
  end
endmodule

// File: rtl/serial_bcd_adder.sv
// Digit-serial BCD adder: one digit per cycle, LSD first, through a single digit adder.
module serial_bcd_adder
  import serial_bcd_adder_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_bcd_adder_if.slave   bus
);
  localparam int unsigned W    = DigitW * NDIG;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              c_q, c_d, cout_q, cout_d, err_q, err_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DigitW-1:0] dig_s;
  logic              dig_c;
  logic              last_dig;
  logic              in_bad;
  logic [W+DigitW-1:0] sum_ext;

  bcd_digit_add u_digit (
    .x  (a_q[DigitW-1:0]),
    .y  (b_q[DigitW-1:0]),
    .ci (c_q),
    .s  (dig_s),
    .co (dig_c)
  );

  assign last_dig = (idx_q == IdxW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StAdd;
      StAdd:   if (last_dig) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      in_bad = in_bad | digit_invalid(bus.a[i*DigitW +: DigitW])
                      | digit_invalid(bus.b[i*DigitW +: DigitW]);
    end
  end

  // Results shift in from the top so digit 0 lands in [3:0] after NDIG steps.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    sum_ext = {dig_s, sum_q};
    if (state_q == StIdle && bus.start) begin
      a_d    = bus.a;
      b_d    = bus.b;
      c_d    = bus.cin;
      idx_d  = '0;
      sum_d  = '0;
      cout_d = 1'b0;
      err_d  = in_bad;
    end else if (state_q == StAdd) begin
      a_d   = a_q >> DigitW;
      b_d   = b_q >> DigitW;
      c_d   = dig_c;
      sum_d = sum_ext[W+DigitW-1:DigitW];
      if (last_dig) begin
        cout_d = dig_c;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy = (state_q == StAdd);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;
endmodule

// File: doc/serial_bcd_adder.md
SERIAL_BCD_ADDER -- requirements
Module: serial_bcd_adder

Interface
REQ-001 Parameter NDIG, default 4, number of BCD digits per operand (legal range 1..8).
REQ-002 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  4*NDIG  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*NDIG  operand B, packed BCD, same packing as a.
REQ-007 cin  input  1  carry into digit 0.
REQ-008 busy  output  1  high while an addition is in progress (ADD state).
REQ-009 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 sum  output  4*NDIG  packed BCD result, same packing as a.
REQ-011 cout  output  1  decimal carry out of the most significant digit.
REQ-012 err  output  1  high if any latched operand digit exceeded 9.

Function
REQ-013 FSM states: IDLE, ADD, DONE; encoding is implementer's choice.
REQ-014 IDLE with start=1: latch a, b, cin; clear digit index; clear sum; compute err from latched digits; go to ADD.
REQ-015 IDLE with start=0: hold state; sum, cout, err hold previous values.
REQ-016 ADD: one digit per cycle, least significant digit first, digit index 0..NDIG-1.
REQ-017 Per digit: f = A_i + B_i + c, 5-bit unsigned; if f > 9 then s_i = (f - 10)[3:0] and c = 1, else s_i = f[3:0] and c = 0.
REQ-018 The carry c for digit 0 is the latched cin; for digit i>0 it is the carry from digit i-1.
REQ-019 The rule in REQ-017 also applies to non-BCD digits (f up to 31); no saturation, only err flags them.
REQ-020 After digit NDIG-1 has been written, cout = final c; go to DONE.
REQ-021 DONE: done=1 for exactly this cycle; unconditionally return to IDLE next cycle.
REQ-022 Latency: start sampled on edge T, then done=1 in the cycle after edge T+NDIG, i.e. NDIG+1 cycles from start to done.
REQ-023 start is ignored in ADD and DONE; a new start is accepted no earlier than the first IDLE cycle after DONE.
REQ-024 Input changes on a, b, cin after latching have no effect on the operation in progress.
REQ-025 sum, cout, err remain stable from done until the next accepted start.
REQ-026 busy = 1 exactly in ADD; done and busy are never high together.

Reset
REQ-027 Resetn=0 forces IDLE immediately, regardless of state, including mid-ADD; the partial result is discarded.
REQ-028 Reset values: busy=0, done=0, sum=0, cout=0, err=0, digit index=0, latched operands=0.
REQ-029 First start accepted on the first rising edge with Resetn=1.

Structure
REQ-030 The FSM state typedef, the BCD digit width (4) and the constant 10 belong in a shared package.
REQ-031 The per-digit add-and-correct step is one combinational sub-module, bcd_digit_add (inputs: two digits and a carry; outputs: digit and carry), instantiated once.
REQ-032 The remaining logic is the sequencer (FSM, digit index counter, operand and result shift registers).

Verification
REQ-033 NDIG=4, a=0x1234, b=0x5678, cin=0, pulse start -> done 5 cycles later, sum=0x6912, cout=0, err=0.
REQ-034 a=0x9999, b=0x0000, cin=1 -> sum=0x0000, cout=1, err=0; every digit produces a carry.
REQ-035 a=0x000F, b=0x0001, cin=0 -> err=1, sum=0x0016, cout=0 (f=16 -> s=6, carry into next digit).
REQ-036 start held high continuously -> operations back-to-back with one IDLE cycle between DONE and the next ADD; exactly one done per operation.
REQ-037 Assert Resetn=0 two cycles into ADD -> busy=0, sum=0, no done pulse; a new start after release completes normally.
REQ-038 Change a and b during ADD -> result matches the operands latched at start.
